// File: rtl/rsa_link_pkg.sv
// Shared types and constants for the byte-serial RSA ciphertext link.
// Contents: receiver state enum, SOF marker default, payload geometry.
package rsa_link_pkg;

  localparam int unsigned RSA_DATA_W      = 64;
  localparam int unsigned RSA_FRAME_BYTES = 8;
  localparam int unsigned RSA_CNT_W       = $clog2(RSA_FRAME_BYTES);
  localparam logic [7:0]  RSA_SOF_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHK     = 2'd2,
    DELIVER = 2'd3
  } state_t;

endpackage

// File: rtl/rsa_link_timer.sv
// Inter-byte timeout counter for the link receiver.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - zero the counter (has priority over run)
//   run       - count one idle cycle
//   expired   - counter has reached TIMEOUT (held there until cleared)
module rsa_link_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [TW-1:0] count;

  assign expired = (count == TW'(TIMEOUT));

  // Saturate at TIMEOUT so a long stall never wraps back to a small value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/rsa_link_rx.sv
// Byte-serial ciphertext receiver feeding the RSA decryptor.
// Frame: SOF_BYTE, 8 payload bytes MSB first, optional XOR checksum byte.
// Build option: define RSA_LINK_CHKSUM_EN to add the checksum byte / CHK state.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   rx_byte, rx_valid  - link data in; accepted when rx_valid && rx_ready
//   rx_ready           - combinational: key_ready && not delivering
//   key_ready          - public key published; gates acceptance
//   dec_ready          - decryptor can take a ciphertext
//   encrypted_message  - delivered ciphertext; shows the new value in the
//                        strobe cycle, holds it afterwards
//   msg_received_sig   - combinational one-cycle delivery strobe
//   frame_err          - registered pulse on checksum error or timeout
//   err_count          - saturating error counter
module rsa_link_rx
  import rsa_link_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE = RSA_SOF_DEFAULT,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  key_ready,
  input  logic                  dec_ready,
  output logic [RSA_DATA_W-1:0] encrypted_message,
  output logic                  msg_received_sig,
  output logic                  frame_err,
  output logic [7:0]            err_count
);

  localparam logic [RSA_CNT_W-1:0] LAST_IDX = RSA_CNT_W'(RSA_FRAME_BYTES - 1);
`ifdef RSA_LINK_CHKSUM_EN
  localparam state_t AFTER_PAYLOAD = CHK;
`else
  localparam state_t AFTER_PAYLOAD = DELIVER;
`endif

  state_t                state, state_nxt;
  logic [RSA_CNT_W-1:0]  cnt, cnt_nxt;
  logic [RSA_DATA_W-1:0] asm_reg, asm_nxt;
  logic [RSA_DATA_W-1:0] msg_q;
  logic                  accept;
  logic                  err_pulse;
  logic                  tmr_clear;
  logic                  tmr_run;
  logic                  tmr_expired;
`ifdef RSA_LINK_CHKSUM_EN
  logic [7:0]            xor_q, xor_nxt;
`endif

  assign rx_ready          = key_ready && (state != DELIVER);
  assign accept            = rx_valid && rx_ready;
  assign msg_received_sig  = (state == DELIVER) && dec_ready;
  // The decryptor samples the ciphertext with the strobe, so bypass the hold register then.
  assign encrypted_message = msg_received_sig ? asm_reg : msg_q;
  assign tmr_run           = (state == PAYLOAD) || (state == CHK);

  rsa_link_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .run     (tmr_run),
    .expired (tmr_expired)
  );

  // Next-state and datapath update; a byte arriving on the expiry cycle still counts.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    asm_nxt   = asm_reg;
    err_pulse = 1'b0;
    tmr_clear = 1'b1;
`ifdef RSA_LINK_CHKSUM_EN
    xor_nxt   = xor_q;
`endif
    case (state)
      IDLE: begin
        if (accept && (rx_byte == SOF_BYTE)) begin
          state_nxt = PAYLOAD;
          cnt_nxt   = '0;
          asm_nxt   = '0;
`ifdef RSA_LINK_CHKSUM_EN
          xor_nxt   = 8'h00;
`endif
        end
      end
      PAYLOAD: begin
        tmr_clear = accept;
        if (accept) begin
          asm_nxt = {asm_reg[RSA_DATA_W-9:0], rx_byte};
          cnt_nxt = cnt + RSA_CNT_W'(1);
`ifdef RSA_LINK_CHKSUM_EN
          xor_nxt = xor_q ^ rx_byte;
`endif
          if (cnt == LAST_IDX) state_nxt = AFTER_PAYLOAD;
        end else if (tmr_expired) begin
          state_nxt = IDLE;
          err_pulse = 1'b1;
        end
      end
`ifdef RSA_LINK_CHKSUM_EN
      CHK: begin
        tmr_clear = accept;
        if (accept) begin
          if (rx_byte == xor_q) begin
            state_nxt = DELIVER;
          end else begin
            state_nxt = IDLE;
            err_pulse = 1'b1;
          end
        end else if (tmr_expired) begin
          state_nxt = IDLE;
          err_pulse = 1'b1;
        end
      end
`endif
      DELIVER: begin
        if (dec_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, assembly and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      asm_reg   <= '0;
      msg_q     <= '0;
      frame_err <= 1'b0;
      err_count <= 8'h00;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      asm_reg   <= asm_nxt;
      frame_err <= err_pulse;
      if (msg_received_sig) msg_q <= asm_reg;
      if (err_pulse && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

`ifdef RSA_LINK_CHKSUM_EN
  // Running checksum of the payload bytes.
  always_ff @(posedge clk) begin
    if (rst) xor_q <= 8'h00;
    else     xor_q <= xor_nxt;
  end
`endif

endmodule

// File: tb/tb_rsa_link_rx.sv
// Self-checking bench for rsa_link_rx: directed scenarios plus random frames,
// compared against a byte-stream frame parser.
module tb_rsa_link_rx;
  import rsa_link_pkg::*;

  typedef logic [8:0]  item_q_t[$];   // bit 8 set = timeout abort marker
  typedef logic [7:0]  byte_q_t[$];
  typedef logic [63:0] msg_q_t[$];

`ifdef RSA_LINK_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic        key_ready;
  logic        dec_ready;
  logic [63:0] encrypted_message;
  logic        msg_received_sig;
  logic        frame_err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  rsa_link_rx dut (
    .clk               (clk),
    .rst               (rst),
    .rx_byte           (rx_byte),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .key_ready         (key_ready),
    .dec_ready         (dec_ready),
    .encrypted_message (encrypted_message),
    .msg_received_sig  (msg_received_sig),
    .frame_err         (frame_err),
    .err_count         (err_count)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] obs_msgs[$];
  int          fe_cycles = 0;
  int          msg_base = 0;
  int          fe_base = 0;
  item_q_t     sent;
  bit          rnd_mode = 1'b0;

  // Output monitor: record every delivery and every cycle frame_err is high.
  always @(negedge clk) begin
    if (!rst) begin
      if (msg_received_sig) obs_msgs.push_back(encrypted_message);
      if (frame_err) fe_cycles++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) to_drive();
  endtask

  // Reference: parse the accepted byte stream into deliveries and error count.
  function automatic void parse(input item_q_t s, output msg_q_t msgs, output int errs);
    int          phase;
    logic [63:0] acc;
    logic [7:0]  x;
    msgs  = {};
    errs  = 0;
    phase = 0;
    acc   = '0;
    x     = '0;
    foreach (s[i]) begin
      if (s[i][8]) begin
        if (phase != 0) errs++;
        phase = 0;
      end else if (phase == 0) begin
        if (s[i][7:0] == 8'hA5) begin
          phase = 1;
          acc   = '0;
          x     = '0;
        end
      end else if (phase <= 8) begin
        acc = acc * 256 + 64'(s[i][7:0]);
        x   = x ^ s[i][7:0];
        phase++;
        if (phase == 9 && !CHK_EN) begin
          msgs.push_back(acc);
          phase = 0;
        end
      end else begin
        if (s[i][7:0] == x) msgs.push_back(acc);
        else errs++;
        phase = 0;
      end
    end
  endfunction

  function automatic byte_q_t make_frame(input logic [63:0] p, input bit good);
    byte_q_t    f;
    logic [7:0] x;
    x = '0;
    f.push_back(8'hA5);
    for (int i = 7; i >= 0; i--) begin
      f.push_back(p[i*8 +: 8]);
      x = x ^ p[i*8 +: 8];
    end
    if (CHK_EN) f.push_back(good ? x : (x ^ 8'h01));
    return f;
  endfunction

  // Present one byte and hold it until accepted; caller is at the drive point.
  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc      = 1'b0;
    rx_byte  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 2000 && !acc; n++) begin
      if (rnd_mode) begin
        key_ready = ($urandom_range(0, 3) != 0);
        dec_ready = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      acc = rx_ready;
      to_drive();
    end
    rx_valid = 1'b0;
    if (acc) sent.push_back({1'b0, b});
    else check("accept_budget", 64'(acc), 64'd1);
  endtask

  task automatic send_range(input byte_q_t f, input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_byte(f[i]);
  endtask

  task automatic check_all(input string tag);
    msg_q_t      em;
    int          errs;
    int          n_obs;
    logic [63:0] last;
    parse(sent, em, errs);
    @(negedge clk);
    n_obs = obs_msgs.size() - msg_base;
    check({tag, ":msg_count"}, 64'(n_obs), 64'(em.size()));
    for (int i = 0; i < em.size() && i < n_obs; i++)
      check({tag, ":msg_value"}, obs_msgs[msg_base + i], em[i]);
    check({tag, ":err_count"}, 64'(err_count), 64'((errs > 255) ? 255 : errs));
    check({tag, ":frame_err_cycles"}, 64'(fe_cycles - fe_base), 64'(errs));
    last = (em.size() > 0) ? em[em.size() - 1] : 64'h0;
    check({tag, ":held_msg"}, encrypted_message, last);
    to_drive();
  endtask

  initial begin
    byte_q_t     f;
    logic [63:0] p;
    logic [7:0]  nb;

    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; key_ready = 1'b1; dec_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset:msg", encrypted_message, 64'h0);
    check("reset:strobe", 64'(msg_received_sig), 64'd0);
    check("reset:frame_err", 64'(frame_err), 64'd0);
    check("reset:err_count", 64'(err_count), 64'd0);
    check("reset:rx_ready", 64'(rx_ready), 64'd1);
    to_drive();

    // Basic frame: strobe in the cycle after the last byte, ready back the cycle after.
    f = make_frame(64'h1122334455667788, 1'b1);
    send_range(f, 0, f.size());
    @(negedge clk);
    check("t1:strobe", 64'(msg_received_sig), 64'd1);
    check("t1:msg", encrypted_message, 64'h1122334455667788);
    check("t1:rx_ready_deliver", 64'(rx_ready), 64'd0);
    to_drive();
    @(negedge clk);
    check("t1:rx_ready_back", 64'(rx_ready), 64'd1);
    check("t1:strobe_once", 64'(msg_received_sig), 64'd0);
    to_drive();
    check_all("t1");

`ifdef RSA_LINK_CHKSUM_EN
    // Bad checksum: error pulse the cycle after the checksum byte, no delivery.
    f = make_frame(64'h1122334455667788, 1'b0);
    send_range(f, 0, f.size());
    @(negedge clk);
    check("t2:frame_err", 64'(frame_err), 64'd1);
    check("t2:no_strobe", 64'(msg_received_sig), 64'd0);
    to_drive();
    @(negedge clk);
    check("t2:frame_err_drop", 64'(frame_err), 64'd0);
    to_drive();
    check_all("t2");
`endif

    // Leading junk dropped; SOF values inside the payload are plain data.
    send_byte(8'h00);
    send_byte(8'hFF);
    f = make_frame(64'hA5A5_0000_A5FF_0011, 1'b1);
    send_range(f, 0, f.size());
    idle(2);
    check_all("t3");

    // Decryptor busy: hold in delivery, strobe the same cycle dec_ready rises.
    dec_ready = 1'b0;
    f = make_frame(64'h0123456789ABCDEF, 1'b1);
    send_range(f, 0, f.size());
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t4:rx_ready_hold", 64'(rx_ready), 64'd0);
      check("t4:no_strobe", 64'(msg_received_sig), 64'd0);
      to_drive();
    end
    dec_ready = 1'b1;
    @(negedge clk);
    check("t4:strobe", 64'(msg_received_sig), 64'd1);
    check("t4:msg", encrypted_message, 64'h0123456789ABCDEF);
    to_drive();
    check_all("t4");

    // Timeout abort after a long stall, then a good frame.
    f = make_frame(64'h1122334455667788, 1'b1);
    send_range(f, 0, 4);
    idle(300);
    sent.push_back(9'h100);
    check_all("t5a");
    f = make_frame(64'h0F1E2D3C4B5A6978, 1'b1);
    send_range(f, 0, f.size());
    idle(2);
    check_all("t5b");

    // Stall shorter than the timeout is tolerated.
    f = make_frame(64'h8877665544332211, 1'b1);
    send_range(f, 0, 4);
    idle(200);
    send_range(f, 4, f.size());
    idle(2);
    check_all("t5c");

    // key_ready low blocks acceptance; raised mid-frame, reception resumes.
    key_ready = 1'b0;
    rx_byte   = 8'hA5;
    rx_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6:rx_ready_nokey", 64'(rx_ready), 64'd0);
      to_drive();
    end
    rx_valid  = 1'b0;
    key_ready = 1'b1;
    f = make_frame(64'hCAFEBABE12345678, 1'b1);
    send_range(f, 0, 4);
    key_ready = 1'b0;
    rx_byte   = f[4];
    rx_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6:rx_ready_midframe", 64'(rx_ready), 64'd0);
      to_drive();
    end
    rx_valid  = 1'b0;
    key_ready = 1'b1;
    send_range(f, 4, f.size());
    idle(2);
    check_all("t6");

    // Reset mid-frame: outputs return to reset values, partial frame lost.
    f = make_frame(64'h1122334455667788, 1'b1);
    send_range(f, 0, 3);
    rst = 1'b1;
    to_drive();
    rst = 1'b0;
    @(negedge clk);
    check("t7:msg", encrypted_message, 64'h0);
    check("t7:err_count", 64'(err_count), 64'd0);
    check("t7:frame_err", 64'(frame_err), 64'd0);
    check("t7:strobe", 64'(msg_received_sig), 64'd0);
    sent.delete();
    msg_base = obs_msgs.size();
    fe_base  = fe_cycles;
    to_drive();
    send_range(f, 3, f.size());
    idle(2);
    check_all("t7a");
    f = make_frame(64'h5555AAAA3333CCCC, 1'b1);
    send_range(f, 0, f.size());
    idle(2);
    check_all("t7b");

    // Random frames with noise, random checksum faults and flow control.
    rnd_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h5A;
        send_byte(nb);
      end
      p = {32'($urandom), 32'($urandom)};
      f = make_frame(p, ($urandom_range(0, 3) != 0));
      send_range(f, 0, f.size());
      idle($urandom_range(0, 2));
    end
    rnd_mode  = 1'b0;
    key_ready = 1'b1;
    dec_ready = 1'b1;
    idle(3);
    check_all("rand");

`ifdef RSA_LINK_CHKSUM_EN
    // Error counter saturation.
    for (int k = 0; k < 260; k++) begin
      f = make_frame({32'($urandom), 32'($urandom)}, 1'b0);
      send_range(f, 0, f.size());
    end
    idle(3);
    check_all("sat");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
